// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces the coin-slot beam sensor, measures blocked width,
// and emits a one-cycle 5c/10c code or a reject pulse to the vending FSM.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int W5_MIN   = 20,
  parameter int W5_MAX   = 40,
  parameter int W10_MIN  = 50,
  parameter int W10_MAX  = 80,
  parameter int GAP      = 2,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       enable,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic       busy
);
  localparam int DB_W = $clog2(DEBOUNCE);
  localparam int GAP_W = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {IDLE, MEASURE, EMIT, GAP_WAIT} state_t;
  state_t state, state_nxt;
  logic s1, s, d, rise, run_done, sat, in5, in10, partial, reject_nxt;
  logic [DB_W-1:0] run;
  logic [CNT_W-1:0] width;
  logic [GAP_W-1:0] gap_cnt;
  logic [1:0] coin_nxt;
  assign run_done = run == DB_W'(DEBOUNCE - 1);
  // rise is the edge at which d flips high, so a coin landing in the last GAP cycle is still seen
  assign rise = s & ~d & run_done;
  assign sat = &width;
  assign jam = sat & d;
  assign busy = state != IDLE;
  assign in5 = width >= CNT_W'(W5_MIN) && width <= CNT_W'(W5_MAX);
  assign in10 = width >= CNT_W'(W10_MIN) && width <= CNT_W'(W10_MAX);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= 1'b0;
      s <= 1'b0;
      d <= 1'b0;
      run <= '0;
      width <= '0;
    end else begin
      s1 <= sensor;
      s <= s1;
      run <= (s == d || run_done) ? '0 : run + 1'b1;
      d <= (s != d && run_done) ? s : d;
      width <= rise ? '0 : (d && !sat) ? width + 1'b1 : width;
    end
  always_comb begin
    state_nxt = state;
    coin_nxt = 2'b00;
    reject_nxt = 1'b0;
    case (state)
      IDLE: state_nxt = rise ? MEASURE : IDLE;
      MEASURE: if (!d) begin
        state_nxt = EMIT;
        coin_nxt = (!enable || partial || sat) ? 2'b00 : in5 ? 2'b01 : in10 ? 2'b10 : 2'b00;
        reject_nxt = coin_nxt == 2'b00;
      end
      EMIT: state_nxt = GAP_WAIT;
      GAP_WAIT: if (gap_cnt == '0) state_nxt = (d || rise) ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      coin <= 2'b00;
      reject <= 1'b0;
      partial <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      coin <= coin_nxt;
      reject <= reject_nxt;
      gap_cnt <= state == EMIT ? GAP_W'(GAP - 1) : (state == GAP_WAIT && gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
      partial <= (rise && (state == EMIT || state == GAP_WAIT)) ? 1'b1 :
                 (state == EMIT || state_nxt == IDLE) ? 1'b0 : partial;
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed and random sensor pulses checked against a width/latency model.
module tb_coin_acceptor;
  localparam int D = 4;
  localparam int GAP = 2;
  logic clk = 1'b0, reset = 1'b0, sensor = 1'b0, enable = 1'b0;
  logic [1:0] coin;
  logic reject, jam, busy;
  int checks = 0, errors = 0;
  int t, busy_first, busy_last, jam_first, jam_last;
  int ev_t[$];
  int ev_v[$];
  int widths[13] = '{30, 60, 45, 10, 20, 40, 19, 41, 50, 80, 49, 81, 3};

  coin_acceptor dut (
    .clk(clk), .reset(reset), .sensor(sensor), .enable(enable),
    .coin(coin), .reject(reject), .jam(jam), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return i < q.size() ? q[i] : 0;
  endfunction

  task automatic clear_log();
    t = 0;
    busy_first = 0;
    busy_last = 0;
    jam_first = 0;
    jam_last = 0;
    ev_t.delete();
    ev_v.delete();
  endtask

  // one sensor sample per step; outputs are observed at the following negedge
  task automatic step(input logic s, input logic en);
    sensor = s;
    enable = en;
    @(negedge clk);
    t++;
    if (busy) begin
      if (busy_first == 0) busy_first = t;
      busy_last = t;
    end
    if (jam) begin
      if (jam_first == 0) jam_first = t;
      jam_last = t;
    end
    if (coin != 2'b00 || reject) begin
      ev_t.push_back(t);
      ev_v.push_back(int'({reject, coin}));
    end
  endtask

  // model: a clean n-cycle pulse is measured as n; code (or reject=4) appears D+3 steps after the fall
  task automatic pulse(input int n, input bit en, input int g_off, input int g_len);
    int exp_v;
    clear_log();
    for (int i = 0; i < n; i++) step(!(i >= g_off && i < g_off + g_len), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) step(1'b0, en);
    exp_v = n < D ? 0 : !en ? 4 : (n >= 20 && n <= 40) ? 1 : (n >= 50 && n <= 80) ? 2 : 4;
    chk($sformatf("n%0d events", n), ev_t.size(), int'(exp_v != 0));
    chk($sformatf("n%0d code", n), at(ev_v, 0), exp_v);
    chk($sformatf("n%0d code_t", n), at(ev_t, 0), exp_v != 0 ? n + D + 3 : 0);
    chk($sformatf("n%0d busy_first", n), busy_first, n >= D ? D + 2 : 0);
    chk($sformatf("n%0d busy_last", n), busy_last, n >= D ? n + D + 3 + GAP : 0);
    chk($sformatf("n%0d jam_first", n), jam_first, n >= 256 ? D + 257 : 0);
    chk($sformatf("n%0d jam_last", n), jam_last, n >= 256 ? n + D + 1 : 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst coin", int'(coin), 0);
    chk("rst reject", int'(reject), 0);
    chk("rst jam", int'(jam), 0);
    chk("rst busy", int'(busy), 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    foreach (widths[i]) pulse(widths[i], 1'b1, 0, 0);
    pulse(30, 1'b1, 10, 3);
    pulse(30, 1'b1, 5, 1);
    pulse(30, 1'b1, 20, 2);
    pulse(30, 1'b0, 0, 0);
    pulse(300, 1'b1, 0, 0);
    for (int r = 0; r < 12; r++) pulse(int'($urandom_range(1, 100)), $urandom_range(0, 3) != 0, 0, 0);
    // second coin rises in the last GAP cycle of the first
    clear_log();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    chk("partial events", ev_t.size(), 2);
    chk("partial first code", at(ev_v, 0), 1);
    chk("partial first t", at(ev_t, 0), 30 + D + 3);
    chk("partial second", at(ev_v, 1), 4);
    chk("partial second t", at(ev_t, 1), 74 + D + 3);
    // reset mid-coin: outputs clear at once, nothing emitted afterwards
    clear_log();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    chk("pre-rst busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("mid-rst coin", int'(coin), 0);
    chk("mid-rst reject", int'(reject), 0);
    chk("mid-rst jam", int'(jam), 0);
    chk("mid-rst busy", int'(busy), 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    chk("post-rst events", ev_t.size(), 0);
    // sensor high through reset release: measured as a fresh, non-partial coin
    sensor = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    reset = 1'b1;
    pulse(35, 1'b1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin validator that drives the `coin` bus consumed by the vending FSMs (`moore_vending`, `mealy_vending`). It synchronises and debounces a raw optical coin-slot sensor and measures how long each coin blocks the beam. It then emits a one-cycle coin code: `2'b01` = 5c, `2'b10` = 10c, `2'b00` = idle. Coins that are out of range, rejected, or jammed never reach the FSM and raise `reject`/`jam` instead.

## Interface
- `DEBOUNCE`, 4: consecutive samples required to change the debounced level. Must be ≥2.
- `W5_MIN`, 20 / `W5_MAX`, 40: inclusive beam-blocked width range, in cycles, for a 5c coin.
- `W10_MIN`, 50 / `W10_MAX`, 80: inclusive width range for a 10c coin.
- `GAP`, 2: minimum number of `coin=00` cycles forced after every emitted code. Must be ≥1.
- `CNT_W`, 8: width counter bits. All W* values must be < 2^CNT_W−1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sensor`  in  1  raw beam-blocked signal; asynchronous and may bounce.
- `enable`  in  1  accept coins when 1. When 0, measured coins are rejected.
- `coin`  out  2  coin code to the vending FSM. Registered.
- `reject`  out  1  one-cycle pulse: a coin was returned. Registered.
- `jam`  out  1  high while the width counter is saturated and the beam is still blocked.
- `busy`  out  1  high in MEASURE, EMIT and GAP.

## Operation
- Synchroniser: 2 flops produce `s`.
- Debouncer: the debounced level `d` takes the value of `s` once `s` has differed from `d` for DEBOUNCE consecutive samples. Any agreeing sample clears the run count. Pulses shorter than DEBOUNCE cycles are invisible.
- Width counter: cleared on the rising edge of `d`, then incremented every cycle `d`=1. It saturates at 2^CNT_W−1. `jam` = saturated & `d`.
- FSM states: IDLE, MEASURE, EMIT, GAP.
  - IDLE → MEASURE on a rising edge of `d`.
  - MEASURE → EMIT on a falling edge of `d`.
  - EMIT lasts 1 cycle and drives the outputs.
  - GAP lasts exactly GAP cycles, then returns to IDLE.
- Classification is decided on the falling edge of `d`; `enable` is sampled at that edge:
  - `enable`=0, coin flagged partial, or width saturated → `reject`.
  - Width in [W5_MIN, W5_MAX] → `coin=01`. 5c wins if the ranges overlap.
  - Width in [W10_MIN, W10_MAX] → `coin=10`.
  - Any other width → `reject`.
- In EMIT, exactly one of `coin≠00` or `reject` is driven.
- Partial coin: a rising edge of `d` while in EMIT or GAP sets a partial flag and restarts the counter. On leaving GAP the FSM goes to MEASURE if `d`=1. That coin is always rejected at its fall, and the flag is cleared in EMIT.
- `coin` is `00` in every state except EMIT. Back-to-back codes are never produced.

## Timing
- Reset values: `coin=00`, `reject=0`, `jam=0`, `busy=0`; synchroniser flops, `d`, counters and flags are 0; state is IDLE.
- Latency, fall side: let k be the first edge at which `sensor` is sampled low.
  - `s` is low after edge k+1.
  - `d` is low after edge k+DEBOUNCE+1.
  - `coin`/`reject` are high for exactly the cycle following edge k+DEBOUNCE+2.
- The rise side has the same delay, so for a clean pulse the measured width equals the raw width in cycles.
- `busy` rises on the cycle after the rising edge of `d` and falls when GAP ends.
- Reset asserted mid-operation: outputs clear immediately, any in-flight coin is lost, no code is emitted. After release the block starts in IDLE. If `sensor` is held high through release, the coin is measured from the first debounced rise; it is not partial.
- A `sensor` held high indefinitely gives `jam`=1 from the saturation cycle onward. On release it produces `reject`.

## Test plan
- Reset low, then `enable`=1 and a clean 30-cycle `sensor` pulse → `coin=01` for exactly 1 cycle at k+DEBOUNCE+2, followed by ≥2 cycles of `00`; `reject` stays 0.
- Clean 60-cycle pulse → `coin=10` for 1 cycle. Clean 45-cycle and 10-cycle pulses → no code, one `reject` pulse each.
- 30-cycle pulse with 1–3-cycle glitches inside it and 3-cycle spikes while idle → exactly one `coin=01`, spikes ignored, `busy` low during the spikes.
- `enable`=0 during a 30-cycle pulse → `coin` stays `00`, one `reject`. With `enable` toggled mid-pulse and 1 at the fall → `coin=01`.
- `sensor` held high for 300 cycles → `jam`=1 from cycle 255 of the `d`-high period; on release `reject`=1 and `coin` stays `00`.
- Reset asserted 20 cycles into a 60-cycle pulse → all outputs 0 immediately, no code after release. A second coin whose debounced rise lands in GAP → it is rejected, and the first coin's code is unaffected.
